gpu_mem_vramcpu_fifo: RTL and testbench
=======================================

// Module: gpu_mem_vramcpu_fifo
// PURPOSE
//  VRAM->CPU read-back path (GPUREAD data for VRAM-to-CPU copies). Accepts 16-bit pixels streamed by the
//  VRAM read engine, packs pixel pairs into 32-bit words (first pixel in [15:0]), and buffers them in a
//  word FIFO drained by the CPU bus. Counts pixels for the whole transfer, zero-pads an odd tail, and
//  signals completion once the last word has been read by the CPU.
// PARAMETERS
//  DEPTH   16  word FIFO entries (power of two)
//  ADDR_W  4   log2(DEPTH)
//  CNT_W   20  pixel counter width (max 1024x512 = 524288 pixels)
// PORTS
//  clk_i        in   1      clock
//  rst_i        in   1      synchronous reset, active high
//  start_i      in   1      start transfer; sampled only in IDLE
//  pix_count_i  in   CNT_W  total pixels of transfer, latched on accepted start_i
//  pix_i        in   16     pixel from VRAM read engine
//  pix_valid_i  in   1      pix_i valid
//  pix_ready_o  out  1      pixel accepted this cycle when pix_valid_i & pix_ready_o
//  cpu_rd_i     in   1      CPU GPUREAD strobe (pop)
//  cpu_data_o   out  32     registered GPUREAD word; holds last popped value
//  cpu_valid_o  out  1      FIFO non-empty (a word is available to pop)
//  busy_o       out  1      state != IDLE
//  done_o       out  1      one-cycle pulse at transfer completion
// BEHAVIOUR
//  Reset: state=IDLE, FIFO ptrs/count=0, half_q=0, remaining=0; all outputs 0 (cpu_data_o=0).
//  FIFO: count-based, COUNT_W=ADDR_W+1; accept = count!=DEPTH, cpu_valid_o = count!=0; pointers wrap
//   modulo DEPTH. Write when full is impossible by construction; pop when empty is ignored (no underflow,
//   cpu_data_o unchanged). Simultaneous write+pop: both happen, count unchanged; when full, write is
//   blocked that cycle even if a pop occurs (decisions use registered count).
//  CPU read: cpu_rd_i & cpu_valid_o -> cpu_data_o <= head word next cycle (1-cycle latency), rd_ptr++.
//   CPU pops are legal in every state, including IDLE.
//  States:
//   IDLE : pix_ready_o=0. start_i: pix_count_i==0 -> stay IDLE, done_o=1 next cycle; else
//          remaining<=pix_count_i, half_q<=0, -> ACTIVE. start_i in any other state ignored.
//   ACTIVE: pix_ready_o = ~half_q | accept. On accepted pixel: remaining--;
//          half_q=0 -> low_q<=pix_i, half_q<=1; half_q=1 -> write {pix_i,low_q}, half_q<=0.
//          When accepted pixel makes remaining 0: half_q was 0 (odd tail) -> PAD; else -> DRAIN.
//   PAD  : pix_ready_o=0; when accept: write {16'h0000,low_q}, half_q<=0, -> DRAIN.
//   DRAIN: pix_ready_o=0; when count==0 -> IDLE, done_o=1 for exactly that transition cycle's next cycle.
//  Extra pixels offered after remaining hits 0 are not accepted (pix_ready_o=0).
//  rst_i mid-transfer: everything returns to reset values next cycle; buffered words discarded, no done_o.
//  Arithmetic: remaining is CNT_W unsigned, never decremented below 0; no ready-to-valid combinational path
//   on the CPU side (cpu_valid_o from registers only). pix_ready_o depends only on registered state.
// TESTING
//  T1 reset: assert rst_i mid-ACTIVE with 3 words queued -> next cycle busy_o=0, cpu_valid_o=0, data=0.
//  T2 even: count=4, pixels 0x1111,0x2222,0x3333,0x4444 -> CPU reads 0x22221111, 0x44443333; done_o
//     pulses once after second pop; busy_o drops same cycle.
//  T3 odd: count=3, pixels 0xAAAA,0xBBBB,0xCCCC -> words 0xBBBBAAAA, 0x0000CCCC; done after 2 pops.
//  T4 full/backpressure: count=40, no CPU reads -> 16 words queued, pix_ready_o=0 with half_q=1;
//     then pop every cycle -> all 20 words in order, no loss/duplication, count never >16.
//  T5 empty/underflow: cpu_rd_i with FIFO empty -> cpu_data_o holds previous word, count stays 0;
//     start_i while busy and count=0 start -> ignored / done_o pulse with no words.
//  T6 random: random pix_valid_i/cpu_rd_i, counts 1..1000 -> scoreboard matches packed stream exactly.

Source files
------------

// File: rtl/gpu_mem_vramcpu_fifo.sv
// VRAM->CPU read-back path: packs 16-bit pixel pairs into 32-bit words, buffers them
// in a word FIFO drained by GPUREAD, zero-pads an odd tail and pulses done_o at the end.
module gpu_mem_vramcpu_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] pix_count_i,
  input  logic [15:0]      pix_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic             cpu_rd_i,
  output logic [31:0]      cpu_data_o,
  output logic             cpu_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int COUNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_PAD,
    S_DRAIN
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic               half_reg;
  logic [15:0]        low_reg;
  logic               done_reg;

  logic [ADDR_W-1:0]  wr_ptr_reg;
  logic [ADDR_W-1:0]  rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [31:0]        cpu_data_reg;
  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic               fifo_valid;
  logic               pix_ready;
  logic               pix_fire;
  logic               pop_fire;
  logic               wr_en;
  logic [31:0]        wr_data;
  logic               last_pix;

  // All handshake decisions come from registered count, so a same-cycle pop
  // never frees a slot for a write.
  assign accept     = (count_reg != COUNT_W'(DEPTH));
  assign fifo_valid = (count_reg != '0);

  always_comb begin
    pix_ready = 1'b0;
    if (state_reg == S_ACTIVE) begin
      pix_ready = ~half_reg | accept;
    end
  end

  assign pix_fire = pix_valid_i & pix_ready;
  assign pop_fire = cpu_rd_i & fifo_valid;
  assign last_pix = pix_fire & (remaining_reg == CNT_W'(1));

  always_comb begin
    wr_en   = 1'b0;
    wr_data = {pix_i, low_reg};
    case (state_reg)
      S_ACTIVE: wr_en = pix_fire & half_reg;
      S_PAD: begin
        wr_en   = accept;
        wr_data = {16'h0000, low_reg};
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Word storage: plain array with write port and registered read port.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpu_data_reg <= '0;
    end else if (pop_fire) begin
      cpu_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      if (wr_en && !pop_fire) begin
        count_reg <= count_reg + COUNT_W'(1);
      end else if (pop_fire && !wr_en) begin
        count_reg <= count_reg - COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      half_reg      <= 1'b0;
      low_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            if (pix_count_i == '0) begin
              done_reg <= 1'b1;
            end else begin
              remaining_reg <= pix_count_i;
              half_reg      <= 1'b0;
              state_reg     <= S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (pix_fire) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (!half_reg) begin
              low_reg  <= pix_i;
              half_reg <= 1'b1;
            end else begin
              half_reg <= 1'b0;
            end
            // A final pixel landing in the low half leaves an odd tail to pad.
            if (last_pix) begin
              state_reg <= half_reg ? S_DRAIN : S_PAD;
            end
          end
        end
        S_PAD: begin
          if (accept) begin
            half_reg  <= 1'b0;
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign pix_ready_o = pix_ready;
  assign cpu_data_o  = cpu_data_reg;
  assign cpu_valid_o = fifo_valid;
  assign busy_o      = (state_reg != S_IDLE);
  assign done_o      = done_reg;

endmodule

// File: tb/tb_gpu_mem_vramcpu_fifo.sv
// Directed and random bench for gpu_mem_vramcpu_fifo: a queue holds the packed words the
// bench expects, filled as pixels are accepted and drained as the CPU pops.
module tb_gpu_mem_vramcpu_fifo;

  localparam int CNT_W = 20;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [CNT_W-1:0] pix_count_i;
  logic [15:0]      pix_i;
  logic             pix_valid_i;
  logic             pix_ready_o;
  logic             cpu_rd_i;
  logic [31:0]      cpu_data_o;
  logic             cpu_valid_o;
  logic             busy_o;
  logic             done_o;

  gpu_mem_vramcpu_fifo #(.DEPTH(16), .ADDR_W(4), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pix_count_i (pix_count_i),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .cpu_rd_i    (cpu_rd_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_valid_o (cpu_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          sent, total, done_cnt, pop_cnt;
  bit          have_low;
  logic [15:0] low_pix;
  bit          last_acc;
  logic [31:0] last_word;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, req);
    end
  endtask

  // One clock cycle, entered and left at a negedge; predicts packing from accepted pixels.
  task automatic cycle(input bit pv, input logic [15:0] p, input bit rd);
    bit acc, pop;
    logic [31:0] w;
    pix_valid_i = pv;
    pix_i       = p;
    cpu_rd_i    = rd;
    acc = pv && pix_ready_o;
    pop = rd && cpu_valid_o;
    if (acc) begin
      sent++;
      if (!have_low) begin
        low_pix  = p;
        have_low = 1'b1;
      end else begin
        exp_q.push_back({p, low_pix});
        have_low = 1'b0;
      end
      if (sent == total && have_low) begin
        exp_q.push_back({16'h0000, low_pix});
        have_low = 1'b0;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    pix_valid_i = 1'b0;
    cpu_rd_i    = 1'b0;
    last_acc    = acc;
    if (done_o) done_cnt++;
    if (pop) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        chk32("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        w = exp_q.pop_front();
        $display("pop %0d: data=%h expected=%h", pop_cnt, cpu_data_o, w);
        chk32("pop_data", cpu_data_o, w);
        last_word = w;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic popc();
    cycle(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic start_xfer(input int n);
    start_i     = 1'b1;
    pix_count_i = CNT_W'(n);
    @(posedge clk_i);
    @(negedge clk_i);
    start_i  = 1'b0;
    total    = n;
    sent     = 0;
    have_low = 1'b0;
    done_cnt = 0;
    pop_cnt  = 0;
    if (done_o) done_cnt++;
    $display("start transfer: %0d pixels", n);
  endtask

  task automatic feed(input logic [15:0] p, input bit rd);
    int k = 0;
    do begin
      cycle(1'b1, p, rd);
      k++;
    end while (!last_acc && k < 64);
    chk1("feed_accept", last_acc, 1'b1);
  endtask

  task automatic drain_all(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      popc();
      k++;
    end
    chk32({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 100) begin
      idle();
      k++;
    end
    chk1({tag, "_done"}, done_o, 1'b1);
    chk1({tag, "_busy_low"}, busy_o, 1'b0);
    chk1({tag, "_empty"}, cpu_valid_o, 1'b0);
    idle();
    chk1({tag, "_pulse"}, done_o, 1'b0);
    chk32({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, thr;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    pix_count_i = '0;
    pix_i       = '0;
    pix_valid_i = 1'b0;
    cpu_rd_i    = 1'b0;
    total       = 0;
    sent        = 0;
    have_low    = 1'b0;
    done_cnt    = 0;
    pop_cnt     = 0;
    last_word   = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_valid", cpu_valid_o, 1'b0);
    chk32("rst_data", cpu_data_o, 32'h0);
    chk1("rst_ready", pix_ready_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    rst_i = 1'b0;
    idle();

    // Even transfer
    start_xfer(4);
    chk1("t2_busy", busy_o, 1'b1);
    feed(16'h1111, 1'b0);
    feed(16'h2222, 1'b0);
    feed(16'h3333, 1'b0);
    feed(16'h4444, 1'b0);
    idle();
    chk1("t2_valid", cpu_valid_o, 1'b1);
    chk1("t2_ready_drain", pix_ready_o, 1'b0);
    popc();
    chk32("t2_first_word", cpu_data_o, 32'h22221111);
    popc();
    chk32("t2_second_word", cpu_data_o, 32'h44443333);
    chk32("t2_no_early_done", 32'(done_cnt), 32'd0);
    chk32("t2_pops", 32'(pop_cnt), 32'd2);
    wait_done("t2");

    // Odd transfer with zero-padded tail
    start_xfer(3);
    feed(16'hAAAA, 1'b0);
    feed(16'hBBBB, 1'b0);
    feed(16'hCCCC, 1'b0);
    drain_all("t3");
    chk32("t3_tail_word", cpu_data_o, 32'h0000CCCC);
    wait_done("t3");

    // Reset mid-transfer with three words buffered
    start_xfer(10);
    for (int i = 0; i < 7; i++) feed(16'(16'h5000 + i), 1'b0);
    idle();
    chk1("t1_valid_before", cpu_valid_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.delete();
    have_low = 1'b0;
    chk1("t1_busy", busy_o, 1'b0);
    chk1("t1_valid", cpu_valid_o, 1'b0);
    chk32("t1_data", cpu_data_o, 32'h0);
    chk1("t1_ready", pix_ready_o, 1'b0);
    idle();
    chk1("t1_no_done", done_o, 1'b0);

    // Full FIFO backpressure, then pop every cycle
    start_xfer(40);
    for (int i = 0; i < 33; i++) feed(16'(16'h4000 + i), 1'b0);
    cycle(1'b1, 16'h4021, 1'b0);
    chk1("t4_ready_full", pix_ready_o, 1'b0);
    chk1("t4_not_accepted", last_acc, 1'b0);
    chk1("t4_valid_full", cpu_valid_o, 1'b1);
    k = 0;
    while ((sent < total || exp_q.size() != 0) && k < 300) begin
      cycle(sent < total, 16'(16'h4000 + sent), 1'b1);
      k++;
    end
    chk32("t4_pops", 32'(pop_cnt), 32'd20);
    chk32("t4_last_word", cpu_data_o, 32'h40274026);
    wait_done("t4");

    // Pop while empty holds the last word
    popc();
    chk32("t5_hold", cpu_data_o, last_word);
    chk1("t5_still_empty", cpu_valid_o, 1'b0);

    // Zero-pixel start: immediate done with no words
    start_i     = 1'b1;
    pix_count_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    chk1("t5_zero_done", done_o, 1'b1);
    chk1("t5_zero_busy", busy_o, 1'b0);
    chk1("t5_zero_valid", cpu_valid_o, 1'b0);
    idle();
    chk1("t5_zero_pulse", done_o, 1'b0);

    // start_i while busy must not relatch the count
    start_xfer(2);
    start_i     = 1'b1;
    pix_count_i = CNT_W'(5);
    feed(16'h7001, 1'b0);
    start_i = 1'b0;
    feed(16'h7002, 1'b0);
    drain_all("t5b");
    chk32("t5b_word", cpu_data_o, 32'h70027001);
    wait_done("t5b");

    // Random traffic
    for (int t = 0; t < 4; t++) begin
      n   = $urandom_range(1, 1000);
      thr = $urandom_range(1, 3);
      start_xfer(n);
      k = 0;
      while ((sent < total || exp_q.size() != 0) && k < 20000) begin
        cycle(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) < thr);
        k++;
      end
      chk32("t6_all_sent", 32'(sent), 32'(total));
      chk32("t6_pops", 32'(pop_cnt), 32'((n + 1) / 2));
      wait_done("t6");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
